dca_matrix_lsu_burst_seq: RTL and testbench

//  Next-generation matrix LSU sequencer: accepts one matrix load/store instruction and emits AXI burst descriptors row by row.

---
 rtl/dca_lsu_burst_pkg.sv | 31 +++
 rtl/dca_lsu_burst_calc.sv | 71 +++++++
 rtl/dca_matrix_lsu_burst_seq.sv | 218 +++++++++++++++++++++
 tb/tb_dca_matrix_lsu_burst_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_lsu_burst_pkg.sv
// ============================================================================
//  Package   : dca_lsu_burst_pkg
//  Purpose   : Shared constants for the matrix LSU burst sequencer: FSM state
//              encoding, default bus geometry and descriptor field widths.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package dca_lsu_burst_pkg;

  // Sequencer FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Default bus geometry (32-bit AXI data path)
  localparam int BYTES       = 4;
  localparam int BW_BYTE_OFS = $clog2(BYTES);

  // Descriptor field widths
  localparam int TXN_LEN_W   = 8;   // AXI ALEN
  localparam int BEATS_W     = 9;   // beat count 1..256

  // AXI bursts must not cross this address boundary when splitting is enabled
  localparam int BOUNDARY_4K = 4096;

endpackage : dca_lsu_burst_pkg

`default_nettype wire

// File: rtl/dca_lsu_burst_calc.sv
// ============================================================================
//  Module    : dca_lsu_burst_calc
//  Purpose   : Combinational burst sizing. From the current byte address and
//              the bytes remaining in the row, produce the beat count, the
//              first-lane offset and the bytes carried by the next burst.
//  Config    : DCA_LSU_4KB_SPLIT_EN - also stop bursts at 4KB boundaries.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module dca_lsu_burst_calc
  import dca_lsu_burst_pkg::*;
#(
  parameter int BW_ADDR       = 32,
  parameter int BW_AXI_DATA   = 8 * BYTES,
  parameter int MAX_BURST_LEN = 16,
  parameter int BW_REM        = 13,
  localparam int N_BYTES      = BW_AXI_DATA / 8,
  localparam int W_OFS        = $clog2(N_BYTES)
) (
  input  logic [BW_ADDR-1:0] cur_addr_i,
  input  logic [BW_REM-1:0]  rem_i,
  output logic [BEATS_W-1:0] beats_o,
  output logic [W_OFS-1:0]   ofs_o,
  output logic [BW_REM-1:0]  byte_cnt_o
);

  logic [31:0] w_ofs;
  logic [31:0] w_rem;
  logic [31:0] w_need;
  logic [31:0] w_beats;
  logic [31:0] w_span;
  logic [31:0] w_cnt;
`ifdef DCA_LSU_4KB_SPLIT_EN
  logic [31:0] w_blk;
  logic [31:0] w_b4k;
`endif

  // Size the next burst: limited by row end, MAX_BURST_LEN and optionally 4KB
  always_comb begin
    w_ofs   = {{(32-W_OFS){1'b0}}, cur_addr_i[W_OFS-1:0]};
    w_rem   = {{(32-BW_REM){1'b0}}, rem_i};
    w_need  = (w_ofs + w_rem + 32'(N_BYTES - 1)) >> W_OFS;
    w_beats = (w_need < 32'(MAX_BURST_LEN)) ? w_need : 32'(MAX_BURST_LEN);
`ifdef DCA_LSU_4KB_SPLIT_EN
    // Beats left before the next 4KB page, counted from the aligned beat
    w_blk   = {20'd0, cur_addr_i[11:0] & ~12'(N_BYTES - 1)};
    w_b4k   = (32'(BOUNDARY_4K) - w_blk) >> W_OFS;
    if (w_b4k < w_beats) w_beats = w_b4k;
`endif
    // Lanes below the start offset in beat 0 carry no data
    w_span  = (w_beats << W_OFS) - w_ofs;
    w_cnt   = (w_span < w_rem) ? w_span : w_rem;
  end

  assign beats_o    = w_beats[BEATS_W-1:0];
  assign ofs_o      = cur_addr_i[W_OFS-1:0];
  assign byte_cnt_o = w_cnt[BW_REM-1:0];

  // Upper bits are provably zero by construction
`ifdef DCA_LSU_4KB_SPLIT_EN
  logic unused_bits;
  assign unused_bits = ^{w_beats[31:BEATS_W], w_cnt[31:BW_REM], cur_addr_i[BW_ADDR-1:12]};
`else
  logic unused_bits;
  assign unused_bits = ^{w_beats[31:BEATS_W], w_cnt[31:BW_REM], cur_addr_i[BW_ADDR-1:W_OFS]};
`endif

endmodule : dca_lsu_burst_calc

`default_nettype wire

// File: rtl/dca_matrix_lsu_burst_seq.sv
// ============================================================================
//  Module    : dca_matrix_lsu_burst_seq
//  Purpose   : Matrix LSU sequencer. Accepts one strided matrix load/store and
//              emits AXI burst descriptors row by row, bounding the number of
//              unacknowledged bursts and pulsing done when all have retired.
//  Config    : DCA_LSU_4KB_SPLIT_EN - bursts never cross a 4KB boundary.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module dca_matrix_lsu_burst_seq
  import dca_lsu_burst_pkg::*;
#(
  parameter int BW_ADDR         = 32,
  parameter int BW_AXI_DATA     = 8 * BYTES,
  parameter int MAX_BURST_LEN   = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BW_ROW          = 8,
  parameter int BW_ROW_BYTES    = 12,
  localparam int W_OFS          = $clog2(BW_AXI_DATA / 8)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    inst_valid,
  output logic                    inst_ready,
  input  logic                    inst_is_write,
  input  logic [BW_ADDR-1:0]      inst_addr,
  input  logic [BW_ADDR-1:0]      inst_stride,
  input  logic [BW_ROW-1:0]       inst_num_row_m1,
  input  logic [BW_ROW_BYTES-1:0] inst_row_bytes_m1,
  output logic                    txn_valid,
  input  logic                    txn_ready,
  output logic                    txn_write,
  output logic [BW_ADDR-1:0]      txn_addr,
  output logic [TXN_LEN_W-1:0]    txn_len,
  output logic [W_OFS-1:0]        txn_byte_ofs,
  output logic [BW_ROW_BYTES:0]   txn_byte_cnt,
  output logic                    txn_last_row,
  output logic                    txn_last_inst,
  input  logic                    rsp_done,
  output logic                    busy,
  output logic                    done
);

  localparam int BW_REM = BW_ROW_BYTES + 1;
  localparam int BW_OUT = $clog2(MAX_OUTSTANDING + 1);

  logic [2:0]              state_q, state_d;
  logic [BW_OUT-1:0]       out_cnt_q, out_cnt_d;

  // Latched instruction
  logic                    is_write_q;
  logic [BW_ADDR-1:0]      inst_addr_q;
  logic [BW_ADDR-1:0]      stride_q;
  logic [BW_ROW-1:0]       num_row_m1_q;
  logic [BW_ROW_BYTES-1:0] row_bytes_m1_q;

  // Walk state
  logic [BW_ADDR-1:0]      cur_addr_q;
  logic [BW_ADDR-1:0]      row_base_q;
  logic [BW_REM-1:0]       rem_q;
  logic [BW_ROW-1:0]       row_q;

  // Registered descriptor
  logic [BW_ADDR-1:0]      txn_addr_q;
  logic [TXN_LEN_W-1:0]    txn_len_q;
  logic [W_OFS-1:0]        txn_ofs_q;
  logic [BW_REM-1:0]       txn_cnt_q;
  logic                    txn_last_row_q;
  logic                    txn_last_inst_q;

  logic [BEATS_W-1:0]      w_beats;
  logic [BEATS_W-1:0]      w_len9;
  logic [W_OFS-1:0]        w_ofs;
  logic [BW_REM-1:0]       w_byte_cnt;
  logic                    w_last_row;
  logic [BW_REM-1:0]       w_row_len;
  logic [BW_ADDR-1:0]      w_next_base;
  logic                    w_accept;
  logic                    w_rsp;
  logic                    w_os_full;

  dca_lsu_burst_calc #(
    .BW_ADDR       (BW_ADDR),
    .BW_AXI_DATA   (BW_AXI_DATA),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .BW_REM        (BW_REM)
  ) u_calc (
    .cur_addr_i (cur_addr_q),
    .rem_i      (rem_q),
    .beats_o    (w_beats),
    .ofs_o      (w_ofs),
    .byte_cnt_o (w_byte_cnt)
  );

  assign w_len9      = w_beats - 9'd1;
  assign w_last_row  = (w_byte_cnt == rem_q);
  assign w_row_len   = {1'b0, row_bytes_m1_q} + BW_REM'(1);
  assign w_next_base = row_base_q + stride_q;
  assign w_os_full   = (out_cnt_q == BW_OUT'(MAX_OUTSTANDING));

  // Handshakes are masked while frozen so no descriptor or response slips past
  assign inst_ready = enable && (state_q == ST_IDLE);
  assign txn_valid  = enable && (state_q == ST_ISSUE) && (!w_os_full || rsp_done);
  assign w_accept   = txn_valid && txn_ready;
  assign w_rsp      = enable && rsp_done && (out_cnt_q != '0);
  assign done       = enable && (state_q == ST_DRAIN) && (out_cnt_q == '0);
  assign busy       = (state_q != ST_IDLE);

  assign txn_write     = is_write_q;
  assign txn_addr      = txn_addr_q;
  assign txn_len       = txn_len_q;
  assign txn_byte_ofs  = txn_ofs_q;
  assign txn_byte_cnt  = txn_cnt_q;
  assign txn_last_row  = txn_last_row_q;
  assign txn_last_inst = txn_last_inst_q;

  logic unused_len_msb;
  assign unused_len_msb = w_len9[BEATS_W-1];

  // Next-state logic for the sequencer FSM and the outstanding counter
  always_comb begin
    state_d   = state_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      ST_IDLE:  if (inst_valid) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_CALC;
      ST_CALC:  state_d = ST_ISSUE;
      ST_ISSUE: if (w_accept) state_d = txn_last_inst_q ? ST_DRAIN : ST_CALC;
      ST_DRAIN: if (out_cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    case ({w_accept, w_rsp})
      2'b10:   out_cnt_d = out_cnt_q + BW_OUT'(1);
      2'b01:   out_cnt_d = out_cnt_q - BW_OUT'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // State, instruction latch, row walk and descriptor registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      out_cnt_q       <= '0;
      is_write_q      <= 1'b0;
      inst_addr_q     <= '0;
      stride_q        <= '0;
      num_row_m1_q    <= '0;
      row_bytes_m1_q  <= '0;
      cur_addr_q      <= '0;
      row_base_q      <= '0;
      rem_q           <= '0;
      row_q           <= '0;
      txn_addr_q      <= '0;
      txn_len_q       <= '0;
      txn_ofs_q       <= '0;
      txn_cnt_q       <= '0;
      txn_last_row_q  <= 1'b0;
      txn_last_inst_q <= 1'b0;
    end else if (enable) begin
      state_q   <= state_d;
      out_cnt_q <= out_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (inst_valid) begin
            is_write_q     <= inst_is_write;
            inst_addr_q    <= inst_addr;
            stride_q       <= inst_stride;
            num_row_m1_q   <= inst_num_row_m1;
            row_bytes_m1_q <= inst_row_bytes_m1;
          end
        end
        ST_LATCH: begin
          cur_addr_q <= inst_addr_q;
          row_base_q <= inst_addr_q;
          rem_q      <= w_row_len;
          row_q      <= '0;
        end
        ST_CALC: begin
          txn_addr_q      <= {cur_addr_q[BW_ADDR-1:W_OFS], {W_OFS{1'b0}}};
          txn_len_q       <= w_len9[TXN_LEN_W-1:0];
          txn_ofs_q       <= w_ofs;
          txn_cnt_q       <= w_byte_cnt;
          txn_last_row_q  <= w_last_row;
          txn_last_inst_q <= w_last_row && (row_q == num_row_m1_q);
        end
        ST_ISSUE: begin
          if (w_accept) begin
            if (txn_last_row_q) begin
              // Row finished: step to the next row start (the last row leaves
              // the walk state alone since DRAIN follows)
              if (!txn_last_inst_q) begin
                row_q      <= row_q + BW_ROW'(1);
                row_base_q <= w_next_base;
                cur_addr_q <= w_next_base;
                rem_q      <= w_row_len;
              end
            end else begin
              cur_addr_q <= cur_addr_q + BW_ADDR'(txn_cnt_q);
              rem_q      <= rem_q - txn_cnt_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding indicates a broken channel engine
  a_rsp_underflow: assert property (@(posedge clk) disable iff (rst)
    !(enable && rsp_done && (out_cnt_q == '0)));
`endif

endmodule : dca_matrix_lsu_burst_seq

`default_nettype wire

// File: tb/tb_dca_matrix_lsu_burst_seq.sv
// ============================================================================
//  Module    : tb_dca_matrix_lsu_burst_seq
//  Purpose   : Self-checking bench for the matrix LSU burst sequencer using a
//              descriptor scoreboard fed from a reference walk of each
//              instruction.
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dca_matrix_lsu_burst_seq;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        inst_valid;
  logic        inst_ready;
  logic        inst_is_write;
  logic [31:0] inst_addr;
  logic [31:0] inst_stride;
  logic [7:0]  inst_num_row_m1;
  logic [11:0] inst_row_bytes_m1;
  logic        txn_valid;
  logic        txn_ready;
  logic        txn_write;
  logic [31:0] txn_addr;
  logic [7:0]  txn_len;
  logic [1:0]  txn_byte_ofs;
  logic [12:0] txn_byte_cnt;
  logic        txn_last_row;
  logic        txn_last_inst;
  logic        rsp_done;
  logic        busy;
  logic        done;

  dca_matrix_lsu_burst_seq #(.MAX_OUTSTANDING(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .inst_is_write     (inst_is_write),
    .inst_addr         (inst_addr),
    .inst_stride       (inst_stride),
    .inst_num_row_m1   (inst_num_row_m1),
    .inst_row_bytes_m1 (inst_row_bytes_m1),
    .txn_valid         (txn_valid),
    .txn_ready         (txn_ready),
    .txn_write         (txn_write),
    .txn_addr          (txn_addr),
    .txn_len           (txn_len),
    .txn_byte_ofs      (txn_byte_ofs),
    .txn_byte_cnt      (txn_byte_cnt),
    .txn_last_row      (txn_last_row),
    .txn_last_inst     (txn_last_inst),
    .rsp_done          (rsp_done),
    .busy              (busy),
    .done              (done)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  int pend = 0;          // accepted bursts not yet answered
  int acc_cnt = 0;       // total accepted bursts
  int done_cnt = 0;      // done pulses seen
  bit auto_rsp = 1'b1;
  int rsp_credit = 0;
  bit ready_rand = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input bit w, input bit li, input bit lr,
                                     input logic [12:0] c, input logic [1:0] o,
                                     input logic [7:0] l, input logic [31:0] a);
    return {6'd0, w, li, lr, c, o, l, a};
  endfunction

  // Reference walk: one expected descriptor per burst, in issue order
  task automatic push_model(input bit wr, input logic [31:0] a0, input logic [31:0] s,
                            input int nrows, input int rbytes);
    logic [31:0] base;
    logic [31:0] a;
    int rem, ofs, need, beats, cnt;
`ifdef DCA_LSU_4KB_SPLIT_EN
    int b4k;
`endif
    base = a0;
    for (int r = 0; r < nrows; r++) begin
      a = base;
      rem = rbytes;
      while (rem > 0) begin
        ofs   = int'(a[1:0]);
        need  = (ofs + rem + 3) / 4;
        beats = (need < 16) ? need : 16;
`ifdef DCA_LSU_4KB_SPLIT_EN
        b4k = (4096 - int'({a[11:2], 2'b00})) / 4;
        if (b4k < beats) beats = b4k;
`endif
        cnt = beats * 4 - ofs;
        if (cnt > rem) cnt = rem;
        rem -= cnt;
        exp_q.push_back(pk(wr, (rem == 0) && (r == nrows - 1), rem == 0, 13'(cnt),
                           a[1:0], 8'(beats - 1), {a[31:2], 2'b00}));
        a = a + 32'(cnt);
      end
      base = base + s;
    end
  endtask

  // Scoreboard side: compare every accepted descriptor, count done pulses
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && txn_valid && txn_ready) begin
        acc_cnt++;
        pend++;
        chk("txn_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("txn_desc", pk(txn_write, txn_last_inst, txn_last_row, txn_byte_cnt,
                             txn_byte_ofs, txn_len, txn_addr), e);
        end
      end
      if (!rst && done) done_cnt++;
    end
  end

  // Channel engine response model
  initial begin
    rsp_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && enable && pend > 0 &&
          (auto_rsp ? ($urandom_range(0, 2) == 0) : (rsp_credit > 0))) begin
        rsp_done = 1'b1;
        pend--;
        if (!auto_rsp) rsp_credit--;
      end else begin
        rsp_done = 1'b0;
      end
    end
  end

  // Descriptor back-pressure
  initial begin
    txn_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      txn_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_inst(input bit wr, input logic [31:0] a, input logic [31:0] s,
                            input int nrows, input int rbytes);
    int w;
    int lat;
    push_model(wr, a, s, nrows, rbytes);
    w = 0;
    @(posedge clk);
    #1;
    while (!inst_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("inst_ready_wait", 64'(inst_ready), 64'd1);
    inst_is_write     = wr;
    inst_addr         = a;
    inst_stride       = s;
    inst_num_row_m1   = 8'(nrows - 1);
    inst_row_bytes_m1 = 12'(rbytes - 1);
    inst_valid        = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    inst_valid = 1'b0;
    while (!txn_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk("first_txn_latency", 64'(lat), 64'd3);
  endtask

  task automatic wait_done();
    int w;
    int d0;
    d0 = done_cnt;
    w = 0;
    while (!done && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("sb_empty_at_done", 64'(exp_q.size()), 64'd0);
    chk("no_pending_at_done", 64'(pend), 64'd0);
    @(posedge clk);
    #3;
    chk("idle_after_done", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #3;
    chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int a0;
    int d0;
    logic [31:0] ra;
    rst = 1'b1;
    enable = 1'b1;
    inst_valid = 1'b0;
    inst_is_write = 1'b0;
    inst_addr = '0;
    inst_stride = '0;
    inst_num_row_m1 = '0;
    inst_row_bytes_m1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {3'd0, txn_valid, txn_write, txn_addr, txn_len, txn_byte_ofs,
                          txn_byte_cnt, txn_last_row, txn_last_inst, busy, done}, 64'd0);
    chk("reset_inst_ready", 64'(inst_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 4 rows x 16B, stride 0x40
    auto_rsp = 1'b1;
    start_inst(1'b0, 32'h1000, 32'h40, 4, 16);
    wait_done();

    // Unaligned single row
    start_inst(1'b1, 32'h1002, 32'h0, 1, 8);
    chk("unaligned_payload", {txn_addr, txn_len, txn_byte_ofs, txn_byte_cnt, txn_last_inst},
        {32'h1000, 8'd2, 2'd2, 13'd8, 1'b1});
    wait_done();

    // Long rows split at MAX_BURST_LEN, with a freeze window and back-pressure
    a0 = acc_cnt;
    start_inst(1'b0, 32'h2000, 32'h100, 2, 100);
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("freeze_busy", 64'(busy), 64'd1);
    chk("freeze_no_valid", 64'(txn_valid), 64'd0);
    chk("freeze_no_accept", 64'(acc_cnt - a0), 64'd0);
    enable = 1'b1;
    ready_rand = 1'b1;
    wait_done();

    // Row straddling a 4KB page
    ready_rand = 1'b0;
    start_inst(1'b1, 32'h0FF8, 32'h0, 1, 16);
`ifdef DCA_LSU_4KB_SPLIT_EN
    chk("page_first_len", 64'(txn_len), 64'd1);
`else
    chk("page_first_len", 64'(txn_len), 64'd3);
`endif
    wait_done();

    // Random instructions, including zero stride and address wrap
    ready_rand = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ra = (i == 4) ? 32'hFFFF_FFF3 : $urandom;
      start_inst(1'($urandom_range(0, 1)), ra,
                 ($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(1, 3), $urandom_range(1, 200));
      wait_done();
    end

    // Outstanding limit: responses withheld
    ready_rand = 1'b0;
    auto_rsp = 1'b0;
    rsp_credit = 0;
    a0 = acc_cnt;
    start_inst(1'b0, 32'h3000, 32'h10, 6, 4);
    repeat (15) @(posedge clk);
    #3;
    chk("os_limit_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("os_limit_valid_low", 64'(txn_valid), 64'd0);
    rsp_credit = 1;
    repeat (10) @(posedge clk);
    #3;
    chk("os_release_one", 64'(acc_cnt - a0), 64'd3);
    chk("os_coincident_hold", 64'(txn_valid), 64'd0);
    rsp_credit = 1;
    repeat (10) @(posedge clk);
    #3;
    chk("os_release_two", 64'(acc_cnt - a0), 64'd4);
    auto_rsp = 1'b1;
    wait_done();

    // Reset in ISSUE with 2 outstanding
    auto_rsp = 1'b0;
    rsp_credit = 0;
    start_inst(1'b1, 32'h4000, 32'h20, 6, 4);
    repeat (12) @(posedge clk);
    #3;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    d0 = done_cnt;
    rst = 1'b1;
    exp_q.delete();
    pend = 0;
    @(negedge clk);
    chk("midrst_outputs", {3'd0, txn_valid, txn_write, txn_addr, txn_len, txn_byte_ofs,
                           txn_byte_cnt, txn_last_row, txn_last_inst, busy, done}, 64'd0);
    chk("midrst_inst_ready", 64'(inst_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    auto_rsp = 1'b1;
    start_inst(1'b0, 32'h1000, 32'h40, 4, 16);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dca_matrix_lsu_burst_seq

`default_nettype wire
